// File: rtl/quad_pkg.sv
// Quadrature phase encoding and state type shared by the emitter and the receive-side decoder,
// so both ends agree on which direction counts up.
package quad_pkg;

    localparam logic [1:0] QPH_0 = 2'b00;
    localparam logic [1:0] QPH_1 = 2'b01;
    localparam logic [1:0] QPH_2 = 2'b11;
    localparam logic [1:0] QPH_3 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_HOLD = 2'd2
    } qe_state_e;

    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        logic [1:0] nxt;
        nxt = QPH_0;
        case (ph)
            QPH_0:   nxt = QPH_1;
            QPH_1:   nxt = QPH_2;
            QPH_2:   nxt = QPH_3;
            default: nxt = QPH_0;
        endcase
        return nxt;
    endfunction

    function automatic logic [1:0] prev_phase(input logic [1:0] ph);
        logic [1:0] prv;
        prv = QPH_0;
        case (ph)
            QPH_0:   prv = QPH_3;
            QPH_1:   prv = QPH_0;
            QPH_2:   prv = QPH_1;
            default: prv = QPH_2;
        endcase
        return prv;
    endfunction

endpackage

// File: rtl/quad_emitter_step_timer.sv
// Hold-time down-counter: load to HOLD-1, count down while in hold, flag the last hold cycle.
module step_timer #(
    parameter int HOLD = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic expire_o
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(HOLD - 1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiring when the count reaches 1 (not 0) makes the next step land exactly HOLD cycles after the previous one.
    assign expire_o = (cnt_q <= CW'(1));

endmodule

// File: rtl/quad_emitter.sv
// Quadrature transmitter: walks {a,b} one Gray step at a time from the current position
// toward an accepted target, holding each state HOLD cycles.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a new target; a/b static
//   ST_STEP | compare position to target; step one phase or finish
//   ST_HOLD | hold the current phase until the step timer expires
module quad_emitter
    import quad_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HOLD  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] target,
    input  logic             target_valid,
    output logic             target_ready,
    output logic             a,
    output logic             b,
    output logic [WIDTH-1:0] position,
    output logic             busy,
    output logic             done
);

    qe_state_e        state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic [1:0]       phase_q, phase_d;
    logic             done_q, done_d;
    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_expire;

    step_timer #(
        .HOLD (HOLD)
    ) u_step_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (tmr_load),
        .dec_i    (tmr_dec),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        pos_d    = pos_q;
        phase_d  = phase_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (target_valid) begin
                    tgt_d   = target;
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (pos_q == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    if (tgt_q > pos_q) begin
                        phase_d = next_phase(phase_q);
                        pos_d   = pos_q + WIDTH'(1);
                    end else begin
                        phase_d = prev_phase(phase_q);
                        pos_d   = pos_q - WIDTH'(1);
                    end
                    tmr_load = 1'b1;
                    state_d  = (HOLD == 1) ? ST_STEP : ST_HOLD;
                end
            end
            ST_HOLD: begin
                tmr_dec = 1'b1;
                if (tmr_expire) begin
                    state_d = ST_STEP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
            pos_q   <= '0;
            phase_q <= QPH_0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            done_q  <= done_d;
        end
    end

    assign a            = phase_q[1];
    assign b            = phase_q[0];
    assign position     = pos_q;
    assign done         = done_q;
    assign busy         = (state_q != ST_IDLE);
    assign target_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_quad_emitter.sv
// Directed bench for quad_emitter (WIDTH=8, HOLD=4) with a debounced loopback decoder model.
module tb_quad_emitter;

    localparam int W = 8;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] target = '0;
    logic         target_valid = 1'b0;
    logic         target_ready;
    logic         a;
    logic         b;
    logic [W-1:0] position;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    quad_emitter #(
        .WIDTH (W),
        .HOLD  (H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .target       (target),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .a            (a),
        .b            (b),
        .position     (position),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept(input logic [W-1:0] t);
        target       = t;
        target_valid = 1'b1;
        tick();
        target_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!done && k < limit) begin
            tick();
            k++;
        end
        check("done_within_limit", {31'b0, done}, 1);
    endtask

    // Loopback receiver: 2-flop sync, 3-sample stability filter, x4 decode.
    logic [1:0]   s1, s2, db;
    logic [1:0]   st;
    logic [W-1:0] dcnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 2'b00; s2 <= 2'b00; db <= 2'b00; st <= 2'd0; dcnt <= '0;
        end else begin
            s1 <= {a, b};
            s2 <= s1;
            if (s2 != s1) st <= 2'd0;
            else if (st != 2'd3) st <= st + 2'd1;
            if (st == 2'd2 && s2 != db) begin
                db <= s2;
                case ({db, s2})
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: dcnt <= dcnt + 8'd1;
                    4'b0100, 4'b1101, 4'b1011, 4'b0010: dcnt <= dcnt - 8'd1;
                    default: ;
                endcase
            end
        end
    end

    // Edge-rule monitor: single-bit changes, >= H cycles apart, no back-to-back done.
    int         cyc = 0;
    int         last_edge = -1000;
    int         viol = 0;
    logic [1:0] pab;
    logic       pdone;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pab <= 2'b00; pdone <= 1'b0; last_edge <= -1000;
        end else begin
            cyc <= cyc + 1;
            if ({a, b} != pab) begin
                if (^({a, b} ^ pab) == 1'b0) viol <= viol + 1;
                else if (cyc - last_edge < H) viol <= viol + 1;
                last_edge <= cyc;
            end
            if (pdone && done) viol <= viol + 1;
            pab   <= {a, b};
            pdone <= done;
        end
    end

    initial begin
        int done_seen;
        logic [W-1:0] t;

        tick(2);
        reset = 1'b0;
        tick();
        check("rst_ab", {30'b0, a, b}, 0);
        check("rst_pos", position, 0);
        check("rst_ready", {31'b0, target_ready}, 1);
        check("rst_busy", {31'b0, busy}, 0);
        done_seen = 0;
        repeat (100) begin
            tick();
            if (done) done_seen++;
        end
        check("idle_no_done", done_seen, 0);

        // Up 0 -> 3
        accept(8'd3);
        check("up_busy", {31'b0, busy}, 1);
        check("up_ready", {31'b0, target_ready}, 0);
        check("up_ab_n", {30'b0, a, b}, 0);
        tick();
        check("up_ab_n1", {30'b0, a, b}, 2'b01);
        check("up_pos_n1", position, 1);
        tick(3);
        check("up_ab_n4", {30'b0, a, b}, 2'b01);
        tick();
        check("up_ab_n5", {30'b0, a, b}, 2'b11);
        check("up_pos_n5", position, 2);
        tick(4);
        check("up_ab_n9", {30'b0, a, b}, 2'b10);
        check("up_pos_n9", position, 3);
        tick(3);
        check("up_done_n12", {31'b0, done}, 0);
        tick();
        check("up_done_n13", {31'b0, done}, 1);
        check("up_busy_n13", {31'b0, busy}, 0);
        check("up_ready_n13", {31'b0, target_ready}, 1);
        tick();
        check("up_done_n14", {31'b0, done}, 0);

        // Target equals position
        accept(8'd3);
        check("eq_busy", {31'b0, busy}, 1);
        tick();
        check("eq_done_n1", {31'b0, done}, 1);
        check("eq_ab", {30'b0, a, b}, 2'b10);
        check("eq_pos", position, 3);

        // Down 3 -> 0
        accept(8'd0);
        tick();
        check("dn_ab_n1", {30'b0, a, b}, 2'b11);
        check("dn_pos_n1", position, 2);
        tick(4);
        check("dn_ab_n5", {30'b0, a, b}, 2'b01);
        check("dn_pos_n5", position, 1);
        tick(4);
        check("dn_ab_n9", {30'b0, a, b}, 2'b00);
        check("dn_pos_n9", position, 0);
        tick(4);
        check("dn_done_n13", {31'b0, done}, 1);

        // Inputs ignored while busy; next accept in the done cycle
        target = 8'd2; target_valid = 1'b1;
        tick();
        target = 8'd200;
        tick();
        check("ign_pos_n1", position, 1);
        target = 8'd7;
        tick(4);
        check("ign_ab_n5", {30'b0, a, b}, 2'b11);
        check("ign_pos_n5", position, 2);
        target = 8'd9;
        tick(4);
        check("ign_done_n9", {31'b0, done}, 1);
        check("ign_pos_n9", position, 2);
        target = 8'd5;
        tick();
        check("b2b_busy_m", {31'b0, busy}, 1);
        check("b2b_done_m", {31'b0, done}, 0);
        target_valid = 1'b0;
        tick();
        check("b2b_ab_m1", {30'b0, a, b}, 2'b10);
        check("b2b_pos_m1", position, 3);
        tick(12);
        check("b2b_done_m13", {31'b0, done}, 1);
        check("b2b_pos_m13", position, 5);
        check("b2b_ab_m13", {30'b0, a, b}, 2'b01);

        // Asynchronous reset mid-move
        tick();
        accept(8'd100);
        tick(6);
        check("mid_pos", position, 7);
        #3 reset = 1'b1;
        #1;
        check("ar_ab", {30'b0, a, b}, 0);
        check("ar_pos", position, 0);
        check("ar_busy", {31'b0, busy}, 0);
        check("ar_ready", {31'b0, target_ready}, 1);
        check("ar_done", {31'b0, done}, 0);
        #2 reset = 1'b0;
        tick(20);
        check("ar_noresume_pos", position, 0);
        check("ar_noresume_busy", {31'b0, busy}, 0);
        check("ar_noresume_ab", {30'b0, a, b}, 0);

        // Loopback with random targets
        for (int i = 0; i < 8; i++) begin
            t = 8'($urandom_range(0, 255));
            if (i == 0) t = 8'd255;
            accept(t);
            wait_done(255 * H + 20);
            check("lb_pos", position, t);
            tick(8);
            check("lb_decoded", dcnt, t);
        end

        check("edge_rules", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
